// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and flag bit positions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MULT = 4'b0010,
    OP_DIV  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_AND  = 4'b0110,
    OP_OR   = 4'b0111,
    OP_XOR  = 4'b1000,
    OP_NOT  = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} alu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine sharing
// one 2N-bit shift register and one N+1-bit adder. Outputs are post-step values.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_mode,   // 0 = multiply, 1 = divide
  input  logic         i_step,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_lo,     // product low half / quotient
  output logic [N-1:0] o_hi,     // product high half / remainder
  output logic         o_last
);
  localparam int CW = $clog2(N);

  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_opd;
  logic           r_mode;
  logic [CW-1:0]  r_cnt;

  logic [N:0]     w_x, w_y, w_sum;
  logic           w_q;
  logic [2*N-1:0] w_nxt;

  always_comb begin
    w_x   = {1'b0, r_acc[2*N-1:N]};
    w_y   = {1'b0, r_opd};
    w_q   = 1'b0;
    w_nxt = r_acc;
    if (r_mode) begin
      // Trial subtract of divisor from the shifted-in partial remainder.
      w_x   = r_acc[2*N-1:N-1];
      w_y   = -{1'b0, r_opd};
      w_sum = w_x + w_y;
      w_q   = ~w_sum[N];
      w_nxt = {(w_q ? w_sum[N-1:0] : w_x[N-1:0]), r_acc[N-2:0], w_q};
    end else begin
      w_sum = w_x + w_y;
      w_nxt = r_acc[0] ? {w_sum, r_acc[N-1:1]} : {1'b0, r_acc[2*N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_opd  <= '0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_mode <= i_mode;
      r_cnt  <= '0;
      r_opd  <= i_mode ? i_b : i_a;
      r_acc  <= {{N{1'b0}}, (i_mode ? i_a : i_b)};
    end else if (i_step) begin
      r_acc  <= w_nxt;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_lo   = w_nxt[N-1:0];
  assign o_hi   = w_nxt[2*N-1:N];
  assign o_last = i_step && (r_cnt == CW'(N-1));

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/shift/add/sub, iterative MULT/DIV behind
// a start/busy/done handshake, NZCV flags and divide-by-zero indication.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   ALUControl,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] resultado,
  output logic [3:0]   flags,
  output logic         divZero
);
  localparam int SW = $clog2(N);

  alu_state_t     r_state, w_state_nxt;
  logic           r_done, r_dz;
  logic [N-1:0]   r_res;
  logic [3:0]     r_flags;

  alu_op_t        w_op;
  logic           w_load, w_mode, w_step, w_wr, w_c, w_v, w_dz;
  logic [N-1:0]   w_res, w_it_lo, w_it_hi;
  logic           w_it_last;
  logic [3:0]     w_fl;
  logic [N:0]     w_add, w_sub;
  logic [2*N-1:0] w_shl, w_shr;

  assign w_op  = alu_op_t'(ALUControl);
  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
  // Widened shifts keep the last bit shifted out at a fixed position.
  assign w_shl = {{N{1'b0}}, a} << b[SW-1:0];
  assign w_shr = {a, {N{1'b0}}} >> b[SW-1:0];

  alu_muldiv_iter #(.N(N)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_mode (w_mode),
    .i_step (w_step),
    .i_a    (a),
    .i_b    (b),
    .o_lo   (w_it_lo),
    .o_hi   (w_it_hi),
    .o_last (w_it_last)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load = 1'b0;
    w_mode = 1'b0;
    w_step = 1'b0;
    w_wr   = 1'b0;
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_dz   = 1'b0;
    case (r_state)
      MUL: begin
        w_step = 1'b1;
        if (w_it_last) begin
          w_wr = 1'b1; w_res = w_it_lo; w_v = |w_it_hi; w_state_nxt = FIN;
        end
      end
      DIV: begin
        w_step = 1'b1;
        if (w_it_last) begin
          w_wr = 1'b1; w_res = w_it_lo; w_state_nxt = FIN;
        end
      end
      default: begin
        // FIN accepts a new request exactly like IDLE.
        w_state_nxt = IDLE;
        if (start) begin
          w_wr        = 1'b1;
          w_state_nxt = FIN;
          case (w_op)
            OP_MULT: begin
              w_wr = 1'b0; w_load = 1'b1; w_state_nxt = MUL;
            end
            OP_DIV: begin
              if (b == '0) begin
                w_res = '1; w_dz = 1'b1;
              end else begin
                w_wr = 1'b0; w_load = 1'b1; w_mode = 1'b1; w_state_nxt = DIV;
              end
            end
            OP_SUB: begin
              w_res = w_sub[N-1:0];
              w_c   = w_sub[N];
              w_v   = (a[N-1] != b[N-1]) && (w_sub[N-1] != a[N-1]);
            end
            OP_SLL: begin w_res = w_shl[N-1:0];     w_c = w_shl[N];   end
            OP_SRL: begin w_res = w_shr[2*N-1:N];   w_c = w_shr[N-1]; end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
            default: begin
              w_res = w_add[N-1:0];
              w_c   = w_add[N];
              w_v   = (a[N-1] == b[N-1]) && (w_add[N-1] != a[N-1]);
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    w_fl         = '0;
    w_fl[FLAG_N] = w_res[N-1];
    w_fl[FLAG_Z] = (w_res == '0);
    w_fl[FLAG_C] = w_c;
    w_fl[FLAG_V] = w_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done  <= 1'b0;
      r_res   <= '0;
      r_flags <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= w_wr;
      if (w_wr) begin
        r_res   <= w_res;
        r_flags <= w_fl;
        r_dz    <= w_dz;
      end
    end
  end

  assign busy      = (r_state == MUL) || (r_state == DIV);
  assign done      = r_done;
  assign resultado = r_res;
  assign flags     = r_flags;
  assign divZero   = r_dz;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at N=8.
module tb_alu_seq;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] ctl = 4'h0;
  logic [7:0] a = 8'h0, b = 8'h0;
  logic       busy, done, divZero;
  logic [7:0] resultado;
  logic [3:0] flags;

  alu_seq #(.N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUControl(ctl), .a(a), .b(b),
    .busy(busy), .done(done), .resultado(resultado), .flags(flags), .divZero(divZero)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] res; logic [3:0] fl; logic dz; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0, t_iss = 0;

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    exp_t e; logic [15:0] t; int d; logic c, v;
    e = '0; c = 1'b0; v = 1'b0; t = '0;
    case (op)
      4'd1: begin e.res = x - y; c = (x >= y);
        d = int'($signed(x)) - int'($signed(y)); v = (d > 127) || (d < -128); end
      4'd2: begin t = {8'h0, x} * {8'h0, y}; e.res = t[7:0]; v = (t[15:8] != 0); end
      4'd3: if (y == 0) begin e.res = 8'hFF; e.dz = 1'b1; end else e.res = x / y;
      4'd4: begin t = {8'h0, x} << y[2:0]; e.res = t[7:0];  c = t[8]; end
      4'd5: begin t = {x, 8'h0} >> y[2:0]; e.res = t[15:8]; c = t[7]; end
      4'd6: e.res = x & y;
      4'd7: e.res = x | y;
      4'd8: e.res = x ^ y;
      4'd9: e.res = ~x;
      default: begin t = {8'h0, x} + {8'h0, y}; e.res = t[7:0]; c = t[8];
        d = int'($signed(x)) + int'($signed(y)); v = (d > 127) || (d < -128); end
    endcase
    e.fl = {e.res[7], (e.res == 8'h0), c, v};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    ctl = op; a = x; b = y; start = 1'b1;
    sb.push_back(model(op, x, y));
    tick();
    start = 1'b0;
    t_iss = cyc - 1;
  endtask

  // exp_busy < 0 skips the busy-cycle count.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int nb; exp_t e;
    nb = 0;
    while (!done && (cyc - t_iss) < 40) begin
      nb += int'(busy);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    if (done) begin
      chk({tag, "_lat"}, 32'(cyc - t_iss), 32'(exp_lat));
      if (exp_busy >= 0) chk({tag, "_busycyc"}, 32'(nb), 32'(exp_busy));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_res"}, 32'(resultado), 32'(e.res));
      chk({tag, "_flags"}, 32'(flags), 32'(e.fl));
      chk({tag, "_dz"}, 32'(divZero), 32'(e.dz));
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_res"}, 32'(resultado), 32'd0);
    chk({tag, "_flags"}, 32'(flags), 32'd0);
    chk({tag, "_dz"}, 32'(divZero), 32'd0);
  endtask

  initial begin
    int nd;
    tick(); tick();
    chk_idle_zero("reset");
    reset = 1'b0;
    tick();

    issue(4'd0, 8'h7F, 8'h01); wait_done("add_ovf", 1, 0);
    chk("add_ovf_const_res", 32'(resultado), 32'h80);
    chk("add_ovf_const_fl", 32'(flags), 32'b1001);
    issue(4'd1, 8'h05, 8'h05); wait_done("sub_eq", 1, 0);
    chk("sub_eq_const_fl", 32'(flags), 32'b0110);
    issue(4'd1, 8'h03, 8'h05); wait_done("sub_neg", 1, 0);

    issue(4'd2, 8'h10, 8'h10); wait_done("mul_ovf", 9, 8);
    chk("mul_ovf_const_fl", 32'(flags), 32'b0101);
    issue(4'd2, 8'h0C, 8'h0B); wait_done("mul_84", 9, 8);
    issue(4'd3, 8'd200, 8'd7); wait_done("div_28", 9, 8);
    chk("div_28_const", 32'(resultado), 32'd28);
    issue(4'd3, 8'd9, 8'd0); wait_done("div_zero", 1, 0);
    chk("div_zero_const_fl", 32'(flags), 32'b1000);

    // start pulse mid-MULT must be ignored
    issue(4'd2, 8'h0C, 8'h0B);
    tick(); tick(); tick();
    ctl = 4'd8; a = 8'hF0; b = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("mul_ignore", 9, -1);
    nd = 0;
    repeat (4) begin tick(); nd += int'(done); end
    chk("mul_ignore_extra_done", 32'(nd), 32'd0);
    issue(4'd8, 8'hF0, 8'h3C); wait_done("xor", 1, 0);

    // start in the done cycle, then back-to-back single-cycle ops
    issue(4'd2, 8'h03, 8'h05); wait_done("mul_15", 9, 8);
    issue(4'd0, 8'h01, 8'h02); wait_done("add_in_done", 1, 0);
    issue(4'd6, 8'hF0, 8'h3C); wait_done("and_b2b", 1, 0);
    issue(4'd7, 8'h0F, 8'h30); wait_done("or_b2b", 1, 0);
    issue(4'd9, 8'h5A, 8'h00); wait_done("not_b2b", 1, 0);
    issue(4'd12, 8'hFF, 8'h01); wait_done("op12_as_add", 1, 0);

    // reset four cycles into a DIV aborts it
    issue(4'd3, 8'd200, 8'd7);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    chk_idle_zero("abort");
    nd = 0;
    repeat (12) begin tick(); nd += int'(done); end
    chk("abort_no_done", 32'(nd), 32'd0);

    issue(4'd0, 8'h22, 8'h11); wait_done("add_after", 1, 0);
    issue(4'd4, 8'h81, 8'h01); wait_done("sll", 1, 0);
    chk("sll_const_res", 32'(resultado), 32'h02);
    chk("sll_const_c", 32'(flags[1]), 32'd1);
    issue(4'd5, 8'h81, 8'h01); wait_done("srl", 1, 0);
    issue(4'd4, 8'h81, 8'h00); wait_done("sll_zero", 1, 0);
    issue(4'd5, 8'h96, 8'h0B); wait_done("srl_amt3", 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Next-generation ALU for the ARMv4 datapath. Replaces the purely combinational result selection with a registered, width-parametrised unit.
- Logic, shift, add and sub complete in one cycle. MULT and DIV run iteratively over N cycles behind a start/busy/done handshake.
- Produces NZCV flags and a divide-by-zero indication. Sits between the register-file read stage and the writeback mux; the control unit stalls on busy.

Parameters:
- N, 32, operand/result width in bits (N >= 4, power of two).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; operands/opcode sampled when start=1 and busy=0.
- ALUControl  in  4  opcode: 0000 ADD, 0001 SUB, 0010 MULT, 0011 DIV, 0100 SLL, 0101 SRL, 0110 AND, 0111 OR, 1000 XOR, 1001 NOT.
- a  in  N  operand A.
- b  in  N  operand B (shift amount for SLL/SRL).
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse when resultado/flags are updated.
- resultado  out  N  registered result; holds until the next done.
- flags  out  4  {N,Z,C,V}; holds until the next done.
- divZero  out  1  set with done for DIV with b=0; cleared on the next done.

Behaviour:
- Reset: state IDLE; busy=0, done=0, resultado=0, flags=0, divZero=0. Applies mid-operation: any in-flight op is aborted and never produces done.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE, start=1, single-cycle op: the result is computed from the sampled operands and registered. Next cycle: done=1; busy stays 0. Latency 1.
- IDLE, start=1, MULT or DIV: latch a, b and opcode; busy=1; go to MUL or DIV with iteration counter = 0.
- MUL: unsigned shift-add, one bit per cycle, N cycles. Then FIN.
- DIV: unsigned restoring division, one quotient bit per cycle, N cycles. Then FIN.
- FIN: registers outputs; done=1, busy=0 in the same cycle; return to IDLE. Total latency N+1 cycles from the start edge; busy is high for exactly N cycles.
- DIV with b=0: no iteration. Next cycle: done=1, resultado = all ones, divZero=1, flags Z=0, N=1, C=0, V=0.
- start while busy=1: ignored; it is neither queued nor allowed to corrupt latched operands.
- start in the same cycle as done: accepted (IDLE is reached that cycle). Back-to-back single-cycle ops give one done per cycle.
- Arithmetic rules:
  - ADD: C = carry out of bit N-1; V = signed overflow.
  - SUB: a - b as a + ~b + 1; C = NOT borrow (ARM convention); V = signed overflow.
  - MULT: resultado = low N bits of the unsigned 2N-bit product; V=1 if the high N bits are nonzero; C=0.
  - DIV: unsigned quotient; remainder discarded; C=0, V=0.
  - SLL/SRL: shift amount = b[$clog2(N)-1:0]; C = last bit shifted out (0 if amount is 0); V=0.
  - AND/OR/XOR/NOT(~a): C=0, V=0.
  - All ops: N flag = resultado[N-1]; Z = (resultado==0).
- Opcodes 1010-1111: executed as ADD (single cycle).

Decomposition:
- alu_pkg:
  - alu_op_t enum holding the 4-bit opcodes above.
  - alu_state_t enum {IDLE, MUL, DIV, FIN}.
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_muldiv_iter: shared 2N-bit shift register, adder/subtractor and counter for MULT/DIV. Interface: load, mode, step, product/quotient out, and a last-iteration strobe.
- The top level holds the FSM, single-cycle datapath and output/flag registers.

Test Plan (N=8):
- Reset, then ADD a=0x7F b=0x01 -> next cycle done=1, resultado=0x80, flags N=1 Z=0 C=0 V=1; busy never high.
- SUB a=0x05 b=0x05 -> resultado=0x00, Z=1, C=1, V=0. SUB a=0x03 b=0x05 -> 0xFE, N=1, C=0.
- MULT a=0x10 b=0x10 -> busy high 8 cycles, done exactly 9 cycles after start, resultado=0x00, Z=1, V=1. MULT 0x0C*0x0B -> 0x84, V=0.
- DIV a=200 b=7 -> done at cycle 9, resultado=28, divZero=0. DIV a=9 b=0 -> done at cycle 1, resultado=0xFF, divZero=1.
- During MULT, pulse start with an XOR op -> ignored; the MULT result is unchanged and only one done occurs. Then XOR 0xF0^0x3C -> 0xCC.
- Assert reset 4 cycles into DIV -> next cycle busy=0, done=0, outputs 0; no done follows. A new ADD then works normally. SLL 0x81 by 1 -> 0x02, C=1.
